// File: rtl/lc2k_pkg.sv
// Shared LC2K machine defaults used by the register file and its bench.
package lc2k_pkg;

    localparam int REG_W    = 32;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_pend_ctr.sv
// Per-register pending-write counter: counts issued-but-not-written-back
// instructions targeting one register. Never wraps in either direction.
module reg_pend_ctr #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              nonzero
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    // Up on issue, down on writeback; both at once cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with writeback bypass and a per-register
// pending-write scoreboard that tracks in-flight destinations.
module reg_file_sb
    import lc2k_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int NUM_REGS = lc2k_pkg::NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int PEND_W   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_addr,
    output logic                     issue_ready,
    input  logic [AW-1:0]            dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic                     err_wr_unexp
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [PEND_W-1:0] pending [NUM_REGS];
    logic              nonzero [NUM_REGS];

    logic wr_is_zero;
    logic iss_is_zero;
    logic wr_ok;
    logic wr_bypass;
    logic issue_acc;
    logic err_set;

    // Register 0 is hardwired when ZERO_REG is set: writes and issues to it vanish.
    assign wr_is_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign iss_is_zero = (ZERO_REG != 0) && (issue_addr == '0);
    assign wr_ok       = wr_en && !wr_is_zero;
    assign wr_bypass   = wr_ok && rst_n;

    assign issue_ready = iss_is_zero || (pending[issue_addr] != PEND_MAX);
    assign issue_acc   = issue_en && issue_ready && !iss_is_zero;

    // A writeback with nothing outstanding is flagged unless a same-edge issue covers it.
    assign err_set = wr_ok && (pending[wr_addr] == '0)
                     && !(issue_acc && (issue_addr == wr_addr));

    // Storage array: cleared on reset, written on an accepted writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Sticky error for unexpected writebacks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_wr_unexp <= 1'b0;
        end else if (err_set) begin
            err_wr_unexp <= 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_ctr
            logic inc_g;
            logic dec_g;

            assign inc_g = issue_acc && (issue_addr == AW'(g));
            assign dec_g = wr_en && (wr_addr == AW'(g));

            reg_pend_ctr #(
                .PEND_W (PEND_W)
            ) u_ctr (
                .clk     (clk),
                .rst_n   (rst_n),
                .inc     (inc_g),
                .dec     (dec_g),
                .count   (pending[g]),
                .nonzero (nonzero[g])
            );
        end

        for (g = 0; g < NUM_RD; g++) begin : g_rd
            logic [AW-1:0] addr_g;
            logic          hit_g;

            assign addr_g = rd_addr[g*AW +: AW];
            assign hit_g  = wr_en && (wr_addr == addr_g);

            // Forward the in-flight writeback so a reader never sees stale data.
            assign rd_data[g*DATA_W +: DATA_W] = (wr_bypass && hit_g) ? wr_data : regs[addr_g];

            // The last outstanding write landing this cycle is resolved by the bypass.
            assign rd_busy[g] = nonzero[addr_g] && !((pending[addr_g] == PEND_ONE) && hit_g);
        end
    endgenerate

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus pushes expected outputs per
// cycle, a negedge monitor pops and compares them.
module tb_reg_file_sb;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          issue_en = 1'b0;
    logic [AW-1:0] issue_addr = '0;
    logic          issue_ready;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;
    logic          err_wr_unexp;

    typedef enum int {K_RD0, K_RD1, K_BUSY0, K_BUSY1, K_READY, K_DBG, K_ERR} kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    reg_file_sb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_busy      (rd_busy),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .issue_en     (issue_en),
        .issue_addr   (issue_addr),
        .issue_ready  (issue_ready),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .err_wr_unexp (err_wr_unexp)
    );

    // Free-running clock and cycle index used to tag expectations.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] sampleOut(kind_t k);
        case (k)
            K_RD0:   return rd_data[DW-1:0];
            K_RD1:   return rd_data[2*DW-1:DW];
            K_BUSY0: return {31'b0, rd_busy[0]};
            K_BUSY1: return {31'b0, rd_busy[1]};
            K_READY: return {31'b0, issue_ready};
            K_DBG:   return dbg_data;
            default: return {31'b0, err_wr_unexp};
        endcase
    endfunction

    function automatic void pushExp(string name, kind_t k, logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = k;
        e.val  = v;
        e.cyc  = cycle;
        sb_q.push_back(e);
    endfunction

    task automatic checkOutput(exp_t e);
        logic [31:0] act;
        act = sampleOut(e.kind);
        checks++;
        if (act !== e.val) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got 0x%h, expected 0x%h", e.name, e.cyc, act, e.val);
        end
    endtask

    // Monitor: on each falling edge, compare everything expected for this cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
            checkOutput(sb_q.pop_front());
        end
    end

    task automatic applyStimulus(input logic rst, input logic we, input int wa, input logic [31:0] wd,
                                 input logic ie, input int ia, input int r0, input int r1, input int da);
        @(posedge clk);
        #1;
        rst_n      = rst;
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = AW'(ia);
        rd_addr    = {AW'(r1), AW'(r0)};
        dbg_addr   = AW'(da);
    endtask

    initial begin
        // Held in reset.
        applyStimulus(0, 1, 3, 32'hDEAD_BEEF, 1, 3, 3, 2, 3);
        pushExp("reset_rd0", K_RD0, 32'h0);
        pushExp("reset_busy0", K_BUSY0, 0);
        pushExp("reset_ready", K_READY, 1);
        pushExp("reset_dbg", K_DBG, 32'h0);
        pushExp("reset_err", K_ERR, 0);

        // Issue r3 so its later writeback is expected.
        applyStimulus(1, 0, 0, 0, 1, 3, 3, 0, 0);
        pushExp("c1_busy0", K_BUSY0, 0);
        pushExp("c1_ready", K_READY, 1);
        pushExp("c1_rd0", K_RD0, 32'h0);

        // Writeback r3: bypass to reader, busy resolved, debug sees old value.
        applyStimulus(1, 1, 3, 32'h0000_00AA, 0, 0, 3, 3, 3);
        pushExp("wb3_rd0_bypass", K_RD0, 32'h0000_00AA);
        pushExp("wb3_busy0_resolved", K_BUSY0, 0);
        pushExp("wb3_dbg_nobypass", K_DBG, 32'h0);

        // Stored r3 readback; also issue r2.
        applyStimulus(1, 0, 0, 0, 1, 2, 3, 0, 3);
        pushExp("r3_rd0", K_RD0, 32'h0000_00AA);
        pushExp("r3_busy0", K_BUSY0, 0);
        pushExp("r3_dbg", K_DBG, 32'h0000_00AA);
        pushExp("r3_err", K_ERR, 0);

        // Writeback r2 with same-cycle read on port 1.
        applyStimulus(1, 1, 2, 32'h0000_1234, 0, 0, 3, 2, 0);
        pushExp("wb2_rd1_bypass", K_RD1, 32'h0000_1234);
        pushExp("wb2_busy1", K_BUSY1, 0);

        // Fill r5 to saturation.
        applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0);
        pushExp("r5_i1_busy", K_BUSY0, 0);
        pushExp("r5_i1_ready", K_READY, 1);
        applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0);
        pushExp("r5_i2_busy", K_BUSY0, 1);
        pushExp("r5_i2_ready", K_READY, 1);
        applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0);
        pushExp("r5_i3_ready", K_READY, 1);
        applyStimulus(1, 0, 0, 0, 1, 5, 5, 0, 0);
        pushExp("r5_full_ready", K_READY, 0);
        pushExp("r5_full_busy", K_BUSY0, 1);

        // One writeback to r5 at pending=3 (fourth issue was dropped).
        applyStimulus(1, 1, 5, 32'h0000_0055, 0, 5, 5, 0, 0);
        pushExp("r5_wb_ready_still_full", K_READY, 0);
        pushExp("r5_wb_busy", K_BUSY0, 1);
        pushExp("r5_wb_rd0_bypass", K_RD0, 32'h0000_0055);
        applyStimulus(1, 0, 0, 0, 0, 5, 5, 0, 0);
        pushExp("r5_after_ready", K_READY, 1);
        pushExp("r5_after_busy", K_BUSY0, 1);
        pushExp("r5_after_rd0", K_RD0, 32'h0000_0055);
        pushExp("r5_after_err", K_ERR, 0);

        // Register 0 ignores writes and issues.
        applyStimulus(1, 1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        pushExp("r0_wr_rd0", K_RD0, 32'h0);
        pushExp("r0_wr_rd1", K_RD1, 32'h0);
        pushExp("r0_ready", K_READY, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        pushExp("r0_after_rd0", K_RD0, 32'h0);
        pushExp("r0_after_busy", K_BUSY0, 0);
        pushExp("r0_after_dbg", K_DBG, 32'h0);
        pushExp("r0_after_err", K_ERR, 0);

        // Unexpected writeback to r4.
        applyStimulus(1, 1, 4, 32'h0000_0044, 0, 0, 4, 0, 0);
        pushExp("r4_wb_err_pre", K_ERR, 0);
        pushExp("r4_wb_rd0", K_RD0, 32'h0000_0044);
        applyStimulus(1, 0, 0, 0, 1, 6, 4, 0, 4);
        pushExp("r4_dbg", K_DBG, 32'h0000_0044);
        pushExp("r4_err_set", K_ERR, 1);
        pushExp("r6_i_ready", K_READY, 1);

        // Issue and writeback to r6 together at pending=1.
        applyStimulus(1, 1, 6, 32'h0000_0066, 1, 6, 6, 0, 0);
        pushExp("r6_both_busy", K_BUSY0, 0);
        pushExp("r6_both_err_hold", K_ERR, 1);
        applyStimulus(1, 0, 0, 0, 0, 6, 6, 0, 6);
        pushExp("r6_after_busy", K_BUSY0, 1);
        pushExp("r6_after_rd0", K_RD0, 32'h0000_0066);
        pushExp("r6_after_dbg", K_DBG, 32'h0000_0066);

        // Two issues to r1, r5 back to full, then reset mid-cycle.
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 5, 0);
        pushExp("r1_i1_busy", K_BUSY0, 0);
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 5, 0);
        pushExp("r1_i2_busy", K_BUSY0, 1);
        applyStimulus(1, 0, 0, 0, 1, 5, 1, 5, 5);
        pushExp("pre_rst_busy0", K_BUSY0, 1);
        pushExp("pre_rst_busy1", K_BUSY1, 1);
        pushExp("pre_rst_ready", K_READY, 1);
        applyStimulus(0, 0, 0, 0, 0, 5, 1, 5, 5);
        pushExp("rst_busy0", K_BUSY0, 0);
        pushExp("rst_busy1", K_BUSY1, 0);
        pushExp("rst_rd0", K_RD0, 32'h0);
        pushExp("rst_rd1", K_RD1, 32'h0);
        pushExp("rst_ready", K_READY, 1);
        pushExp("rst_dbg", K_DBG, 32'h0);
        pushExp("rst_err", K_ERR, 0);

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb_q.size() > 0) begin
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
            errors += sb_q.size();
            checks += sb_q.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter NUM_REGS, default 8: register count, power of two ≥2; AW = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: 1 = register 0 reads 0 and ignores writes and issues.
REQ-005 Parameter PEND_W, default 2: width of each per-register pending-write counter.
REQ-006 Port clk, input, 1: single clock, rising edge.
REQ-007 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 Port rd_addr, input, NUM_RD*AW: packed read addresses, port i at bits [i*AW +: AW].
REQ-009 Port rd_data, output, NUM_RD*DATA_W: packed read data.
REQ-010 Port rd_busy, output, NUM_RD: port i's register has an unresolved pending write.
REQ-011 Port wr_en, input, 1: writeback strobe.
REQ-012 Port wr_addr, input, AW: writeback destination.
REQ-013 Port wr_data, input, DATA_W: writeback value.
REQ-014 Port issue_en, input, 1: an instruction targeting issue_addr is issued.
REQ-015 Port issue_addr, input, AW: destination of the issued instruction.
REQ-016 Port issue_ready, output, 1: the counter for issue_addr can accept one more issue.
REQ-017 Port dbg_addr, input, AW: debug read address, with no bypass.
REQ-018 Port dbg_data, output, DATA_W: stored value of dbg_addr.
REQ-019 Port err_wr_unexp, output, 1: sticky flag for a writeback to a register with no pending write.

Function
REQ-020 Write: on a clk rising edge with wr_en=1, regs[wr_addr] <= wr_data; suppressed when ZERO_REG=1 and wr_addr=0.
REQ-021 Read: rd_data[i] is combinational from regs[rd_addr[i]], zero-latency.
REQ-022 Bypass: when wr_en=1, wr_addr=rd_addr[i], and the write is not suppressed, rd_data[i]=wr_data in the same cycle.
REQ-023 Register 0 with ZERO_REG=1: rd_data=0, rd_busy=0, dbg_data=0.
REQ-024 Scoreboard issue: a clock edge with issue_en=1 and issue_ready=1 increments pending[issue_addr]; issue_en with issue_ready=0 is ignored.
REQ-025 issue_ready = (pending[issue_addr] != 2^PEND_W-1); forced to 1 for register 0 when ZERO_REG=1.
REQ-026 Scoreboard writeback: an edge with wr_en=1 and pending[wr_addr]>0 decrements pending[wr_addr].
REQ-027 If pending[wr_addr]=0 on wr_en=1, the counter stays 0, the data is still written, and err_wr_unexp sets to 1 (unless reg 0 with ZERO_REG=1).
REQ-028 Simultaneous accepted issue and writeback to the same address leave the counter unchanged and do not set err_wr_unexp.
REQ-029 rd_busy[i] = (pending[rd_addr[i]] != 0), except it is 0 when pending=1 and a same-cycle wr_en targets rd_addr[i], because the bypass resolves it.
REQ-030 Issue and writeback to different addresses update both counters independently in the same cycle.
REQ-031 Counters never wrap; saturation is prevented by issue_ready.
REQ-032 dbg_data = regs[dbg_addr], combinational, with no bypass.

Reset
REQ-033 While rst_n=0, asynchronously: all regs=0, all pending=0, err_wr_unexp=0.
REQ-034 Resulting outputs while rst_n=0: rd_data=0, rd_busy=0, issue_ready=1, dbg_data=0.
REQ-035 rst_n asserted mid-operation discards in-flight pending state; a same-edge write is lost.
REQ-036 Reset release is synchronous to clk at the integration level; the first write edge is the first edge after release.

Structure
REQ-037 Shared package lc2k_pkg holds the LC2K defaults: REG_W=32, NUM_REGS=8, and the register-address typedef.
REQ-038 Sub-module reg_pend_ctr: one PEND_W up/down counter with inc, dec, and a nonzero flag, instantiated NUM_REGS times.
REQ-039 No other sub-modules; read muxes and bypass are inline.

Verification
REQ-040 Reset, then write r3=0x0000_00AA; next cycle rd_addr0=3 -> rd_data0=0x0000_00AA, rd_busy0=0.
REQ-041 wr_en, wr_addr=2, wr_data=0x1234 with rd_addr1=2 in the same cycle -> rd_data1=0x1234 that cycle (bypass).
REQ-042 Three issues to r5 (PEND_W=2) -> issue_ready=0 for r5; a 4th issue is ignored; one writeback -> issue_ready=1, rd_busy=1 (pending=2).
REQ-043 Write r0=0xFFFF_FFFF and issue to r0, with ZERO_REG=1 -> rd_data=0, rd_busy=0, err_wr_unexp=0.
REQ-044 Writeback to r4 with pending=0 -> r4 updated, err_wr_unexp=1 and holding; simultaneous issue+writeback to r6 with pending=1 -> pending stays 1.
REQ-045 Issue r1 twice, pulse rst_n low mid-cycle -> immediately rd_busy=0, all rd_data=0, issue_ready=1.
